xadc_drp_poller: RTL and testbench
==================================

// Module: xadc_drp_poller
// PURPOSE
//  Sequences XADC DRP reads: on each sweep trigger, reads the enabled status registers (temp, VCCINT,
//  VCCAUX, VCCBRAM, AUX2, AUX3) one at a time, holds each result, and flags timeouts.
//  Sits between the XADC primitive's DRP port and the display/switch-select logic, replacing per-channel polling.
// PARAMETERS
//  EN_MASK   6'b111111  channel enable bits; bit i = table index i (0:0x00 1:0x01 2:0x02 3:0x06 4:0x12 5:0x13)
//  TRIG_MODE 0          0 = sweep on EOS pulse; 1 = sweep every PERIOD cycles (internal counter)
//  PERIOD    16'd50000  cycles between internal triggers (TRIG_MODE=1), >=2
//  TIMEOUT   8'd255     max cycles in WAIT for DRDY before abandoning a read, >=1
// PORTS
//  DCLK          in   1   clock, DRP clock domain
//  RESET_N       in   1   asynchronous reset, active low
//  EOS           in   1   XADC end-of-sequence pulse (single cycle)
//  DO            in   16  DRP read data
//  DRDY          in   1   DRP data ready (single cycle)
//  DADDR         out  7   DRP address
//  DEN           out  1   DRP enable, one-cycle pulse
//  DWE           out  1   DRP write enable, tied 0
//  DI            out  16  DRP write data, tied 0
//  ERR_CLR       in   1   clears TIMEOUT_ERR and OVERRUN
//  SEL           in   3   selects MON_OUT source (0..5 = table index, 6/7 -> 16'h0000)
//  MEASURED_0..5 out  16  last good read per table index
//  VALID         out  6   bit i set after first good read of index i; cleared only by reset
//  MON_OUT       out  16  combinational mux of MEASURED_x by SEL
//  BUSY          out  1   high in any state but IDLE
//  SWEEP_DONE    out  1   one-cycle pulse when a sweep finishes
//  TIMEOUT_ERR   out  1   sticky: a read timed out
//  OVERRUN       out  1   sticky: a trigger was dropped
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, pending=0, period counter=0. Reset mid-read aborts; late DRDY is ignored.
//  FSM: IDLE -> ISSUE -> WAIT -> NEXT -> (ISSUE | IDLE).
//  IDLE: on trigger or pending, idx = lowest set bit of EN_MASK, clear pending, -> ISSUE. EN_MASK=0: never leave.
//  ISSUE: DEN=1 for exactly this cycle, DADDR=table[idx], wait counter=0, -> WAIT.
//  WAIT: DADDR held. DRDY=1: MEASURED_idx<=DO, VALID[idx]<=1 next edge, -> NEXT.
//   Counter reaches TIMEOUT without DRDY: TIMEOUT_ERR<=1, MEASURED_idx unchanged, -> NEXT.
//   DRDY and timeout in same cycle: DRDY wins (data stored, no error).
//  NEXT: idx = next higher enabled index -> ISSUE; none left -> SWEEP_DONE=1 this cycle, -> IDLE.
//  Latency: DEN at cycle t, DRDY at t+k -> MEASURED updated at edge ending t+k; per channel 2+k cycles.
//  DRDY outside WAIT is ignored. DWE/DI never asserted.
//  Triggers: TRIG_MODE=0 uses EOS; TRIG_MODE=1 counter wraps PERIOD-1 -> 0 and pulses trigger on wrap;
//   EOS ignored. Trigger while BUSY: pending<=1 (single-deep). Trigger while BUSY with pending already
//   set: dropped, OVERRUN<=1. Trigger in the same cycle IDLE is left: counted as busy trigger.
//  ERR_CLR clears both sticky flags. A same-cycle set event wins over ERR_CLR.
//  Disabled indices: never read, MEASURED and VALID stay 0.
// TESTING
//  EN_MASK=all, EOS pulse, DRDY 3 cycles after each DEN with DO=16'hA5A0+i ->
//   DADDR 00,01,02,06,12,13 in order; MEASURED_i=A5A0+i; VALID=6'h3F; one SWEEP_DONE; DEN high 6 cycles total.
//  Withhold DRDY for index 2, TIMEOUT=8 -> TIMEOUT_ERR=1 after 8 WAIT cycles; MEASURED_2 unchanged;
//   sweep continues to 0x06; ERR_CLR pulse -> TIMEOUT_ERR=0.
//  EOS twice during one sweep -> one extra sweep follows immediately; OVERRUN=1 from the second EOS.
//  EN_MASK=6'b110000 -> only DADDR 0x12, 0x13 read; MEASURED_0..3 stay 0; SEL=4 -> MON_OUT=MEASURED_4; SEL=7 -> 0.
//  TRIG_MODE=1, PERIOD=100, DRDY after 1 cycle -> sweeps start every 100 cycles; EOS has no effect.
//  Assert RESET_N low while in WAIT, then DRDY -> all outputs 0, FSM IDLE, no MEASURED update.

Source files
------------

// File: rtl/xadc_drp_poller.sv
// xadc_drp_poller: walks the enabled XADC status registers over the DRP port
// once per sweep trigger, keeps the last good value of each, and raises sticky
// flags for DRDY timeouts and dropped triggers.
module xadc_drp_poller #(
    parameter logic [5:0]  EN_MASK   = 6'b111111,
    parameter int          TRIG_MODE = 0,
    parameter logic [15:0] PERIOD    = 16'd50000,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        DCLK,
    input  logic        RESET_N,
    input  logic        EOS,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic [6:0]  DADDR,
    output logic        DEN,
    output logic        DWE,
    output logic [15:0] DI,
    input  logic        ERR_CLR,
    input  logic [2:0]  SEL,
    output logic [15:0] MEASURED_0,
    output logic [15:0] MEASURED_1,
    output logic [15:0] MEASURED_2,
    output logic [15:0] MEASURED_3,
    output logic [15:0] MEASURED_4,
    output logic [15:0] MEASURED_5,
    output logic [5:0]  VALID,
    output logic [15:0] MON_OUT,
    output logic        BUSY,
    output logic        SWEEP_DONE,
    output logic        TIMEOUT_ERR,
    output logic        OVERRUN
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_idx;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_period_cnt;
    logic        r_pending;
    logic        r_timeout_err;
    logic        r_overrun;
    logic [5:0]  r_valid;
    logic [15:0] r_meas [6];

    logic        w_trig;
    logic [3:0]  w_first;
    logic [3:0]  w_next;
    logic        w_drdy_hit;
    logic        w_timeout;
    logic        w_start;
    logic        w_busy_trig;

    // DRP address of each table index.
    function automatic logic [6:0] f_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    f_addr = 7'h00;
            3'd1:    f_addr = 7'h01;
            3'd2:    f_addr = 7'h02;
            3'd3:    f_addr = 7'h06;
            3'd4:    f_addr = 7'h12;
            3'd5:    f_addr = 7'h13;
            default: f_addr = 7'h00;
        endcase
    endfunction

    // Lowest enabled index >= from; bit 3 of the result flags "found".
    function automatic logic [3:0] f_find(input logic [3:0] from);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 5; i >= 0; i--) begin
            if (EN_MASK[i] && (i >= int'(from))) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    // Trigger source, channel search and WAIT-exit conditions.
    always_comb begin
        w_trig      = (TRIG_MODE == 1) ? (r_period_cnt == PERIOD - 16'd1) : EOS;
        w_first     = f_find(4'd0);
        w_next      = f_find({1'b0, r_idx} + 4'd1);
        w_drdy_hit  = (r_state == S_WAIT) && DRDY;
        w_timeout   = (r_state == S_WAIT) && !DRDY && (r_wait_cnt == TIMEOUT - 8'd1);
        w_start     = (r_state == S_IDLE) && (w_trig || r_pending) && w_first[3];
        // Leaving IDLE on a pending request consumes it, so a trigger arriving then re-arms it.
        w_busy_trig = w_trig && ((r_state != S_IDLE) || r_pending);
    end

    // State register.
    always_ff @(posedge DCLK or negedge RESET_N) begin
        // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: assigning a default first keeps this block free of inferred latches.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_drdy_hit || w_timeout) w_state_nxt = S_NEXT;
            S_NEXT:  w_state_nxt = w_next[3] ? S_ISSUE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: DRP strobe/address, busy and end-of-sweep pulse.
    always_comb begin
        DEN        = (r_state == S_ISSUE);
        DADDR      = ((r_state == S_ISSUE) || (r_state == S_WAIT)) ? f_addr(r_idx) : 7'h00;
        DWE        = 1'b0;
        DI         = 16'h0000;
        BUSY       = (r_state != S_IDLE);
        SWEEP_DONE = (r_state == S_NEXT) && !w_next[3];
    end

    // Channel index and per-read WAIT cycle counter.
    always_ff @(posedge DCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_idx      <= 3'd0;
            r_wait_cnt <= 8'd0;
        end else begin
            if (w_start)                              r_idx <= w_first[2:0];
            else if ((r_state == S_NEXT) && w_next[3]) r_idx <= w_next[2:0];
            if (r_state == S_ISSUE)     r_wait_cnt <= 8'd0;
            else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Internal periodic trigger counter (wraps PERIOD-1 -> 0).
    always_ff @(posedge DCLK or negedge RESET_N) begin
        if (!RESET_N)            r_period_cnt <= 16'd0;
        else if (TRIG_MODE == 1) r_period_cnt <= (r_period_cnt == PERIOD - 16'd1) ? 16'd0 : r_period_cnt + 16'd1;
    end

    // Single-deep pending trigger and sticky error flags; a set beats ERR_CLR.
    always_ff @(posedge DCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pending     <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_busy_trig)  r_pending <= 1'b1;
            else if (w_start) r_pending <= 1'b0;
            if (w_busy_trig && r_pending && (r_state != S_IDLE)) r_overrun <= 1'b1;
            else if (ERR_CLR)                                    r_overrun <= 1'b0;
            if (w_timeout)    r_timeout_err <= 1'b1;
            else if (ERR_CLR) r_timeout_err <= 1'b0;
        end
    end

    // Result bank: capture DO on DRDY for the channel in flight.
    always_ff @(posedge DCLK or negedge RESET_N) begin
        // NOTE: the result bank is plain flops and must read 0 after reset, so it is reset like any register.
        if (!RESET_N) begin
            for (int i = 0; i < 6; i++) r_meas[i] <= 16'h0000;
            r_valid <= 6'd0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_drdy_hit && (r_idx == 3'(i))) begin
                    r_meas[i]  <= DO;
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

    // Result fan-out and display mux.
    always_comb begin
        MEASURED_0  = r_meas[0];
        MEASURED_1  = r_meas[1];
        MEASURED_2  = r_meas[2];
        MEASURED_3  = r_meas[3];
        MEASURED_4  = r_meas[4];
        MEASURED_5  = r_meas[5];
        VALID       = r_valid;
        TIMEOUT_ERR = r_timeout_err;
        OVERRUN     = r_overrun;
        case (SEL)
            3'd0:    MON_OUT = r_meas[0];
            3'd1:    MON_OUT = r_meas[1];
            3'd2:    MON_OUT = r_meas[2];
            3'd3:    MON_OUT = r_meas[3];
            3'd4:    MON_OUT = r_meas[4];
            3'd5:    MON_OUT = r_meas[5];
            default: MON_OUT = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_xadc_drp_poller.sv
// Testbench for xadc_drp_poller: three instances (full mask with short timeout,
// partial mask, periodic trigger) driven by behavioural DRP responders.
module tb_xadc_drp_poller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [6:0] addr_of(input int i);
        case (i)
            0: return 7'h00;
            1: return 7'h01;
            2: return 7'h02;
            3: return 7'h06;
            4: return 7'h12;
            5: return 7'h13;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int idx_of(input logic [6:0] a);
        for (int i = 0; i < 6; i++) if (addr_of(i) == a) return i;
        return 0;
    endfunction

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] exp;
    } sel_vec_t;

    // ---------------- instance A: all channels, TIMEOUT = 8 ----------------
    logic        a_rst_n = 0, a_eos = 0, a_drdy = 0, a_erc = 0;
    logic [15:0] a_do = 0;
    logic [2:0]  a_sel = 0;
    logic [6:0]  a_daddr;
    logic        a_den, a_dwe, a_busy, a_sd, a_terr, a_ovr;
    logic [15:0] a_di, a_mon;
    logic [15:0] a_meas [6];
    logic [5:0]  a_valid;

    xadc_drp_poller #(.EN_MASK(6'b111111), .TRIG_MODE(0), .PERIOD(16'd50000), .TIMEOUT(8'd8)) dut_a (
        .DCLK(clk), .RESET_N(a_rst_n), .EOS(a_eos), .DO(a_do), .DRDY(a_drdy),
        .DADDR(a_daddr), .DEN(a_den), .DWE(a_dwe), .DI(a_di), .ERR_CLR(a_erc), .SEL(a_sel),
        .MEASURED_0(a_meas[0]), .MEASURED_1(a_meas[1]), .MEASURED_2(a_meas[2]),
        .MEASURED_3(a_meas[3]), .MEASURED_4(a_meas[4]), .MEASURED_5(a_meas[5]),
        .VALID(a_valid), .MON_OUT(a_mon), .BUSY(a_busy), .SWEEP_DONE(a_sd),
        .TIMEOUT_ERR(a_terr), .OVERRUN(a_ovr)
    );

    // Responder A: answers each DEN after a_lat cycles (or never for a_drop);
    // in random mode it also keeps the transaction-level reference model.
    int          a_lat = 3;
    int          a_drop = -1;
    logic [15:0] a_base = 16'hA5A0;
    bit          a_rand = 0;
    int          a_cnt = 0;
    int          a_cur = 0;
    logic [15:0] a_data = 0;
    logic [15:0] m_meas [6];
    logic [5:0]  m_valid = 0;
    logic        m_terr = 0;

    always @(negedge clk) begin
        a_drdy = 1'b0;
        if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 0) begin
                a_drdy = 1'b1;
                a_do   = a_data;
                if (a_rand) begin
                    m_meas[a_cur]  = a_data;
                    m_valid[a_cur] = 1'b1;
                end
            end
        end
        if (a_den) begin
            a_cur = idx_of(a_daddr);
            if (a_rand) begin
                a_data = 16'($urandom);
                if ($urandom_range(0, 9) == 0) begin
                    a_cnt  = 0;
                    m_terr = 1'b1;
                end else begin
                    a_cnt = $urandom_range(1, 8);
                end
            end else begin
                a_data = a_base + 16'(a_cur);
                a_cnt  = (a_cur == a_drop) ? 0 : a_lat;
            end
        end
    end

    // Monitor A: logs DEN cycles/addresses, SWEEP_DONE cycles, TIMEOUT_ERR rise.
    int         a_den_cyc [$];
    logic [6:0] a_den_addr [$];
    int         a_sd_cyc [$];
    int         a_terr_rise = -1;
    logic       a_terr_d = 0;
    int         a_exp_ptr = 0;

    always @(negedge clk) begin
        if (a_den) begin
            a_den_cyc.push_back(cyc);
            a_den_addr.push_back(a_daddr);
            if (a_rand) begin
                check("rand_daddr_order", a_daddr, addr_of(a_exp_ptr));
                a_exp_ptr = (a_exp_ptr + 1) % 6;
            end
        end
        if (a_sd) a_sd_cyc.push_back(cyc);
        if (a_terr && !a_terr_d && a_terr_rise < 0) a_terr_rise = cyc;
        a_terr_d = a_terr;
    end

    task automatic a_clear();
        a_den_cyc.delete();
        a_den_addr.delete();
        a_sd_cyc.delete();
        a_terr_rise = -1;
    endtask

    task automatic a_wait_sd(input int n, input int budget);
        int k = 0;
        while (a_sd_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        check($sformatf("a_sweep_done_seen_%0d", n), 32'(a_sd_cyc.size() >= n), 1);
    endtask

    task automatic a_check_zero(input string tag);
        check({tag, "_daddr"}, a_daddr, 0);
        check({tag, "_den"}, a_den, 0);
        check({tag, "_dwe_di"}, {a_dwe, a_di}, 0);
        check({tag, "_valid"}, a_valid, 0);
        check({tag, "_mon"}, a_mon, 0);
        check({tag, "_flags"}, {a_busy, a_sd, a_terr, a_ovr}, 0);
        for (int i = 0; i < 6; i++) check($sformatf("%s_meas%0d", tag, i), a_meas[i], 0);
    endtask

    // ---------------- instance B: EN_MASK = 6'b110000 ----------------
    logic        b_rst_n = 0, b_eos = 0, b_drdy = 0;
    logic [15:0] b_do = 0;
    logic [2:0]  b_sel = 0;
    logic [6:0]  b_daddr;
    logic        b_den, b_dwe, b_busy, b_sd, b_terr, b_ovr;
    logic [15:0] b_di, b_mon;
    logic [15:0] b_meas [6];
    logic [5:0]  b_valid;

    xadc_drp_poller #(.EN_MASK(6'b110000), .TRIG_MODE(0), .PERIOD(16'd50000), .TIMEOUT(8'd255)) dut_b (
        .DCLK(clk), .RESET_N(b_rst_n), .EOS(b_eos), .DO(b_do), .DRDY(b_drdy),
        .DADDR(b_daddr), .DEN(b_den), .DWE(b_dwe), .DI(b_di), .ERR_CLR(1'b0), .SEL(b_sel),
        .MEASURED_0(b_meas[0]), .MEASURED_1(b_meas[1]), .MEASURED_2(b_meas[2]),
        .MEASURED_3(b_meas[3]), .MEASURED_4(b_meas[4]), .MEASURED_5(b_meas[5]),
        .VALID(b_valid), .MON_OUT(b_mon), .BUSY(b_busy), .SWEEP_DONE(b_sd),
        .TIMEOUT_ERR(b_terr), .OVERRUN(b_ovr)
    );

    int          b_cnt = 0;
    logic [15:0] b_data = 0;
    logic [6:0]  b_den_addr [$];
    int          b_sd_cnt = 0;

    // Responder/monitor B: DRDY two cycles after DEN with DO = B000 + index.
    always @(negedge clk) begin
        b_drdy = 1'b0;
        if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) begin
                b_drdy = 1'b1;
                b_do   = b_data;
            end
        end
        if (b_den) begin
            b_data = 16'hB000 + 16'(idx_of(b_daddr));
            b_cnt  = 2;
            b_den_addr.push_back(b_daddr);
        end
        if (b_sd) b_sd_cnt++;
    end

    // ---------------- instance C: TRIG_MODE = 1, PERIOD = 100 ----------------
    logic        c_rst_n = 0, c_eos = 0, c_drdy = 0;
    logic [15:0] c_do = 0;
    logic [6:0]  c_daddr;
    logic        c_den, c_dwe, c_busy, c_sd, c_terr, c_ovr;
    logic [15:0] c_di, c_mon;
    logic [15:0] c_meas [6];
    logic [5:0]  c_valid;

    xadc_drp_poller #(.EN_MASK(6'b111111), .TRIG_MODE(1), .PERIOD(16'd100), .TIMEOUT(8'd255)) dut_c (
        .DCLK(clk), .RESET_N(c_rst_n), .EOS(c_eos), .DO(c_do), .DRDY(c_drdy),
        .DADDR(c_daddr), .DEN(c_den), .DWE(c_dwe), .DI(c_di), .ERR_CLR(1'b0), .SEL(3'd0),
        .MEASURED_0(c_meas[0]), .MEASURED_1(c_meas[1]), .MEASURED_2(c_meas[2]),
        .MEASURED_3(c_meas[3]), .MEASURED_4(c_meas[4]), .MEASURED_5(c_meas[5]),
        .VALID(c_valid), .MON_OUT(c_mon), .BUSY(c_busy), .SWEEP_DONE(c_sd),
        .TIMEOUT_ERR(c_terr), .OVERRUN(c_ovr)
    );

    int          c_cnt = 0;
    logic [15:0] c_data = 0;
    int          c_start_cyc [$];
    int          c_den_cnt = 0;
    int          c_sd_cnt = 0;

    // Responder/monitor C: DRDY one cycle after DEN; logs sweep start cycles.
    always @(negedge clk) begin
        c_drdy = 1'b0;
        if (c_cnt > 0) begin
            c_cnt--;
            if (c_cnt == 0) begin
                c_drdy = 1'b1;
                c_do   = c_data;
            end
        end
        if (c_den) begin
            c_data = 16'hC000 + 16'(idx_of(c_daddr));
            c_cnt  = 1;
            c_den_cnt++;
            if (c_daddr == 7'h00) c_start_cyc.push_back(cyc);
        end
        if (c_sd) c_sd_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        sel_vec_t a_tab [8];
        sel_vec_t b_tab [8];
        int       k;
        int       c_rel;
        int       idle_run;

        for (int i = 0; i < 8; i++) begin
            a_tab[i].sel = 3'(i);
            a_tab[i].exp = (i < 6) ? 16'hA5A0 + 16'(i) : 16'h0000;
            b_tab[i].sel = 3'(i);
            b_tab[i].exp = (i == 4 || i == 5) ? 16'hB000 + 16'(i) : 16'h0000;
        end
        for (int i = 0; i < 6; i++) m_meas[i] = 16'h0000;

        repeat (3) tick();
        a_check_zero("reset");
        a_rst_n = 1'b1;
        repeat (2) tick();

        // Full sweep, DRDY 3 cycles after each DEN.
        a_clear();
        a_eos = 1'b1; tick(); a_eos = 1'b0;
        a_wait_sd(1, 300);
        check("sweep_den_cycles", a_den_addr.size(), 6);
        for (int i = 0; i < 6 && i < a_den_addr.size(); i++)
            check($sformatf("sweep_daddr%0d", i), a_den_addr[i], addr_of(i));
        for (int i = 1; i < 6 && i < a_den_cyc.size(); i++)
            check($sformatf("sweep_den_spacing%0d", i), a_den_cyc[i] - a_den_cyc[i-1], 5);
        for (int i = 0; i < 6; i++)
            check($sformatf("sweep_meas%0d", i), a_meas[i], 16'hA5A0 + 16'(i));
        check("sweep_valid", a_valid, 6'h3F);
        check("sweep_flags", {a_terr, a_ovr}, 0);
        repeat (10) tick();
        check("sweep_done_once", a_sd_cyc.size(), 1);
        check("sweep_idle_after", a_busy, 0);

        // MON_OUT selection table.
        for (int i = 0; i < 8; i++) begin
            a_sel = a_tab[i].sel;
            #1;
            check($sformatf("a_mon_sel%0d", i), a_mon, a_tab[i].exp);
        end
        a_sel = 3'd0;

        // Index 2 never answers: timeout after 8 WAIT cycles, sweep continues.
        a_drop = 2; a_base = 16'h5B00;
        a_clear(); tick();
        a_eos = 1'b1; tick(); a_eos = 1'b0;
        a_wait_sd(1, 300);
        check("to_den_cycles", a_den_addr.size(), 6);
        check("to_err_rise_delay", a_terr_rise - a_den_cyc[2], 9);
        check("to_next_den_delay", a_den_cyc[3] - a_den_cyc[2], 10);
        check("to_next_daddr", a_den_addr[3], 7'h06);
        check("to_meas2_kept", a_meas[2], 16'hA5A2);
        check("to_meas1_new", a_meas[1], 16'h5B01);
        check("to_meas3_new", a_meas[3], 16'h5B03);
        check("to_err_set", a_terr, 1);
        a_erc = 1'b1; tick(); a_erc = 1'b0;
        check("to_err_cleared", a_terr, 0);

        // DRDY on the last allowed WAIT cycle beats the timeout.
        a_drop = -1; a_lat = 8; a_base = 16'h6C00;
        a_clear(); tick();
        a_eos = 1'b1; tick(); a_eos = 1'b0;
        a_wait_sd(1, 300);
        for (int i = 0; i < 6; i++)
            check($sformatf("late_meas%0d", i), a_meas[i], 16'h6C00 + 16'(i));
        check("late_no_err", a_terr, 0);
        check("late_den_spacing", a_den_cyc[1] - a_den_cyc[0], 10);

        // Two EOS during a sweep: one pending sweep, second sets OVERRUN even with ERR_CLR.
        a_lat = 3; a_base = 16'h7D00;
        a_clear(); tick();
        a_eos = 1'b1; tick(); a_eos = 1'b0;
        repeat (6) tick();
        a_eos = 1'b1; tick(); a_eos = 1'b0;
        check("ovr_pending_only", a_ovr, 0);
        repeat (6) tick();
        a_eos = 1'b1; a_erc = 1'b1; tick(); a_eos = 1'b0; a_erc = 1'b0;
        check("ovr_set_beats_clr", a_ovr, 1);
        a_wait_sd(2, 400);
        check("ovr_den_cycles", a_den_addr.size(), 12);
        check("ovr_back_to_back", a_den_cyc[6] - a_sd_cyc[0], 2);
        repeat (40) tick();
        check("ovr_single_extra", a_sd_cyc.size(), 2);
        a_erc = 1'b1; tick(); a_erc = 1'b0;
        check("ovr_cleared", a_ovr, 0);

        // Reset while in WAIT; the late DRDY must be ignored.
        a_lat = 6;
        a_clear(); tick();
        a_eos = 1'b1; tick(); a_eos = 1'b0;
        k = 0;
        while (a_den_addr.size() < 1 && k < 20) begin tick(); k++; end
        check("rst_den_seen", a_den_addr.size(), 1);
        repeat (2) tick();
        a_rst_n = 1'b0;
        tick();
        a_check_zero("rst_wait");
        a_rst_n = 1'b1;
        repeat (10) tick();
        check("rst_meas0", a_meas[0], 0);
        check("rst_valid", a_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_no_new_den", a_den_addr.size(), 1);

        // Partial channel mask.
        b_rst_n = 1'b1; tick();
        b_eos = 1'b1; tick(); b_eos = 1'b0;
        k = 0;
        while (b_sd_cnt < 1 && k < 100) begin tick(); k++; end
        check("b_sweep_done", b_sd_cnt, 1);
        check("b_den_cycles", b_den_addr.size(), 2);
        check("b_daddr0", b_den_addr[0], 7'h12);
        check("b_daddr1", b_den_addr[1], 7'h13);
        for (int i = 0; i < 4; i++) check($sformatf("b_meas%0d_zero", i), b_meas[i], 0);
        check("b_meas4", b_meas[4], 16'hB004);
        check("b_meas5", b_meas[5], 16'hB005);
        check("b_valid", b_valid, 6'b110000);
        for (int i = 0; i < 8; i++) begin
            b_sel = b_tab[i].sel;
            #1;
            check($sformatf("b_mon_sel%0d", i), b_mon, b_tab[i].exp);
        end

        // Periodic trigger; EOS must have no effect.
        c_rst_n = 1'b1;
        c_rel = cyc;
        for (int i = 0; i < 330; i++) begin
            c_eos = (i % 7 == 0);
            tick();
        end
        c_eos = 1'b0;
        check("c_sweep_starts", c_start_cyc.size(), 3);
        check("c_first_start", c_start_cyc[0] - c_rel, 100);
        check("c_period1", c_start_cyc[1] - c_start_cyc[0], 100);
        check("c_period2", c_start_cyc[2] - c_start_cyc[1], 100);
        check("c_den_total", c_den_cnt, 18);
        check("c_sweeps_done", c_sd_cnt, 3);
        check("c_meas5", c_meas[5], 16'hC005);
        check("c_no_overrun", c_ovr, 0);

        // Randomised EOS and DRDY latency against the reference model.
        a_rst_n = 1'b0; tick(); a_rst_n = 1'b1;
        a_clear();
        a_exp_ptr = 0;
        a_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            a_eos = ($urandom_range(0, 39) == 0);
            tick();
        end
        a_eos = 1'b0;
        idle_run = 0;
        k = 0;
        while (idle_run < 3 && k < 1000) begin
            tick();
            idle_run = a_busy ? 0 : idle_run + 1;
            k++;
        end
        check("rand_drained", 32'(idle_run >= 3), 1);
        a_rand = 1'b0;
        for (int i = 0; i < 6; i++)
            check($sformatf("rand_meas%0d", i), a_meas[i], m_meas[i]);
        check("rand_valid", a_valid, m_valid);
        check("rand_timeout_err", a_terr, m_terr);
        check("rand_some_sweeps", 32'(a_sd_cyc.size() > 0), 1);
        check("rand_den_per_sweep", a_den_addr.size(), 6 * a_sd_cyc.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
